// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN result path.
package cnn_pkg;
  typedef enum logic {IDLE, SEND} ser_state_t;
  function automatic int num_groups(int nok, int npe);
    return (nok + npe - 1) / npe;
  endfunction
endpackage

// File: rtl/kernel_group_serializer_if.sv
// kernel_group_serializer_if: pixel-vector input handshake and per-beat result bus.
interface kernel_group_serializer_if #(
  parameter int NumberOfK = 4,
  parameter int BitSize = 32,
  parameter int ProcessingElements = 2
);
  logic in_valid;
  logic in_ready;
  logic [NumberOfK-1:0][BitSize-1:0] in_data;
  logic [NumberOfK-1:0] out_valid;
  logic [ProcessingElements-1:0][BitSize-1:0] out_data;
  logic image_last;
  logic busy;
  modport master (output in_valid, in_data, input in_ready, out_valid, out_data, image_last, busy);
  modport slave (input in_valid, in_data, output in_ready, out_valid, out_data, image_last, busy);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-2 depth, async active-high reset.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/kernel_group_serializer.sv
// kernel_group_serializer: splits buffered per-pixel kernel vectors into lane-wide beats for mem_module.
module kernel_group_serializer
  import cnn_pkg::*;
#(
  parameter int NumberOfK = 4,
  parameter int BitSize = 32,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth = 2,
  parameter int FifoDepth = 4
) (
  input logic clk,
  input logic res,
  kernel_group_serializer_if.slave bus
);
  localparam int G = num_groups(NumberOfK, ProcessingElements);
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int NP = ImageWidth * ImageWidth;
  localparam int PW = NP > 1 ? $clog2(NP) : 1;
  typedef logic [NumberOfK-1:0][BitSize-1:0] vec_t;
  typedef logic [G-1:0][ProcessingElements-1:0][BitSize-1:0] pad_t;
  ser_state_t state;
  logic [GW-1:0] grp, nb;
  logic [PW-1:0] pix;
  vec_t vec, rdata, src;
  pad_t pad;
  logic [NumberOfK-1:0] nxt_valid;
  logic rdy, full, empty, restart, go, last;
  sync_fifo #(.WIDTH(NumberOfK * BitSize), .DEPTH(FifoDepth)) u_fifo (
    .clk(clk), .rst(res), .push(bus.in_valid & bus.in_ready), .pop(restart & !empty),
    .wdata(bus.in_data), .rdata(rdata), .full(full), .empty(empty)
  );
  assign bus.in_ready = rdy & !full;
  assign bus.busy = !empty || state == SEND;
  // restart: the next beat is beat 0 of a freshly popped vector (or nothing, if the FIFO is empty)
  always_comb begin
    restart = state == IDLE || grp == GW'(G - 1);
    go = !restart || !empty;
    src = restart ? rdata : vec;
    nb = restart ? '0 : grp + 1'b1;
    last = nb == GW'(G - 1);
  end
  // lanes beyond the last kernel of the final group are padded with zeros
  for (genvar k = 0; k < G * ProcessingElements; k++) begin : g_pad
    if (k < NumberOfK) begin : g_src
      assign pad[k / ProcessingElements][k % ProcessingElements] = src[k];
      assign nxt_valid[k] = nb == GW'(k / ProcessingElements);
    end else begin : g_zero
      assign pad[k / ProcessingElements][k % ProcessingElements] = '0;
    end
  end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      state <= IDLE;
      grp <= '0;
      pix <= '0;
      vec <= '0;
      rdy <= 1'b0;
      bus.out_valid <= '0;
      bus.out_data <= '0;
      bus.image_last <= 1'b0;
    end else begin
      rdy <= 1'b1;
      state <= go ? SEND : IDLE;
      grp <= nb;
      vec <= src;
      bus.out_valid <= go ? nxt_valid : '0;
      bus.out_data <= go ? pad[nb] : '0;
      bus.image_last <= go && last && pix == PW'(NP - 1);
      if (go && last) pix <= pix == PW'(NP - 1) ? '0 : pix + 1'b1;
    end
endmodule

// File: tb/tb_kernel_group_serializer.sv
// tb_kernel_group_serializer: table-driven vectors and scoreboard for the serializer (K=4 and K=3 builds).
module tb_kernel_group_serializer;
  typedef struct {
    logic [3:0]  v;
    logic [63:0] d;
    logic        l;
  } beat_t;
  typedef struct {
    logic [127:0] pix;
    logic [3:0]   v0;
    logic [63:0]  d0;
    logic [3:0]   v1;
    logic [63:0]  d1;
  } vec_t;

  logic clk = 0, res = 1;
  always #5 clk = ~clk;

  kernel_group_serializer_if #(.NumberOfK(4), .BitSize(32), .ProcessingElements(2)) aif ();
  kernel_group_serializer_if #(.NumberOfK(3), .BitSize(32), .ProcessingElements(2)) bif ();

  kernel_group_serializer #(.NumberOfK(4), .BitSize(32), .ProcessingElements(2), .ImageWidth(2), .FifoDepth(4))
    dut_a (.clk(clk), .res(res), .bus(aif.slave));
  kernel_group_serializer #(.NumberOfK(3), .BitSize(32), .ProcessingElements(2), .ImageWidth(2), .FifoDepth(4))
    dut_b (.clk(clk), .res(res), .bus(bif.slave));

  beat_t q[$];
  int tests = 0, fails = 0, model_pix = 0, run = 0, max_run = 0, last_cnt = 0;
  bit ready_low = 0;

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic void expect_px(vec_t t);
    q.push_back('{t.v0, t.d0, 1'b0});
    q.push_back('{t.v1, t.d1, model_pix == 3});
    model_pix = (model_pix + 1) % 4;
  endfunction

  always @(negedge clk)
    if (!res) begin
      if (aif.in_valid && !aif.in_ready) ready_low = 1;
      if (aif.image_last) last_cnt++;
      if (aif.out_valid != 0) begin
        beat_t e;
        run++;
        if (run > max_run) max_run = run;
        if (q.size() == 0) check("unexpected_beat", {aif.out_valid, aif.out_data}, 0);
        else begin
          e = q.pop_front();
          check("beat_a", {aif.out_valid, aif.out_data, aif.image_last}, {e.v, e.d, e.l});
        end
      end else run = 0;
    end

  task automatic push(vec_t t);
    int n = 0;
    aif.in_valid = 1;
    aif.in_data = t.pix;
    while (!aif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!aif.in_ready) fail_now("push_ready");
    else begin
      @(posedge clk);
      expect_px(t);
      @(negedge clk);
    end
    aif.in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || aif.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", q.size(), 0);
  endtask

  task automatic do_reset();
    res = 1;
    q.delete();
    model_pix = 0;
    @(negedge clk);
    res = 0;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[4];
    vec_t t;
    int n;
    tbl[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, 4'b0011, {32'd2, 32'd1}, 4'b1100, {32'd4, 32'd3}};
    tbl[1] = '{{32'hdeadbeef, 32'h01234567, 32'hffffffff, 32'h0}, 4'b0011, {32'hffffffff, 32'h0},
               4'b1100, {32'hdeadbeef, 32'h01234567}};
    tbl[2] = '{{32'h80000000, 32'h1, 32'haaaa5555, 32'h5555aaaa}, 4'b0011, {32'haaaa5555, 32'h5555aaaa},
               4'b1100, {32'h80000000, 32'h1}};
    tbl[3] = '{{32'h11, 32'h22, 32'h33, 32'h44}, 4'b0011, {32'h33, 32'h44}, 4'b1100, {32'h11, 32'h22}};

    // reset held with in_valid high: nothing may be accepted
    aif.in_valid = 1;
    aif.in_data = tbl[0].pix;
    bif.in_valid = 0;
    bif.in_data = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_outputs", {aif.out_valid, aif.out_data, aif.image_last, aif.busy, aif.in_ready}, 0);
    end
    aif.in_valid = 0;
    res = 0;
    @(negedge clk);
    check("ready_after_rst", aif.in_ready, 1);
    check("no_push_in_rst", aif.busy, 0);

    // K=3: partial final group, latency from push
    check("b_ready", bif.in_ready, 1);
    bif.in_valid = 1;
    bif.in_data = {32'd7, 32'd6, 32'd5};
    @(posedge clk);
    #1 bif.in_valid = 0;
    @(negedge clk);
    check("b_latency", {bif.out_valid, bif.out_data}, 0);
    @(negedge clk);
    check("b_beat0", {bif.out_valid, bif.out_data}, {3'b011, 32'd6, 32'd5});
    @(negedge clk);
    check("b_beat1", {bif.out_valid, bif.out_data}, {3'b100, 32'd0, 32'd7});
    @(negedge clk);
    check("b_idle", {bif.out_valid, bif.out_data}, 0);

    // single pixel, then idle
    push(tbl[0]);
    drain();
    check("idle_outputs", {aif.out_valid, aif.out_data, aif.image_last}, 0);

    // four back-to-back pixels from the table, then a fifth after the wrap
    do_reset();
    max_run = 0;
    last_cnt = 0;
    for (int i = 0; i < 4; i++) push(tbl[i]);
    drain();
    check("no_bubble_run", max_run, 8);
    check("one_image_last", last_cnt, 1);
    push(tbl[1]);
    drain();
    check("wrap_no_last", last_cnt, 1);

    // overflow: enough consecutive pushes that the FIFO fills and stalls input
    do_reset();
    ready_low = 0;
    for (int i = 0; i < 10; i++) begin
      t.pix = {$urandom, $urandom, $urandom, $urandom};
      t.v0 = 4'b0011;
      t.d0 = t.pix[63:0];
      t.v1 = 4'b1100;
      t.d1 = t.pix[127:64];
      push(t);
    end
    drain();
    check("in_ready_dropped", ready_low, 1);

    // async reset during pixel 2 with pixel 3 still buffered
    do_reset();
    for (int i = 0; i < 4; i++) push(tbl[i]);
    n = 0;
    while (!(aif.out_valid == 4'b0011 && aif.out_data == tbl[2].d0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) fail_now("wait_pixel2");
    #2 res = 1;
    #1 check("async_rst_out", {aif.out_valid, aif.out_data, aif.image_last, aif.busy, aif.in_ready}, 0);
    q.delete();
    model_pix = 0;
    @(negedge clk);
    res = 0;
    repeat (3) @(negedge clk);
    check("fifo_flushed", aif.busy, 0);
    last_cnt = 0;
    for (int i = 0; i < 4; i++) push(tbl[i]);
    drain();
    check("new_image_last", last_cnt, 1);

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
